// File: rtl/serial_detect_sched.sv
// Round-robin scheduler that shares one serial "11" Mealy detector among N_REQ requesters.
// Each granted word is shifted MSB-first into the detector, and the hit count is returned with the requester id.
module serial_detect_sched #(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4,
  parameter int ID_W   = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*WORD_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [CNT_W-1:0]        rsp_count,
  input  logic                    rsp_ready,
  output logic                    det_in,
  input  logic                    det_out,
  output logic                    busy
);

  localparam int BC_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);
  localparam logic [ID_W-1:0] PTR_INIT = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  state_t            next_state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   cand;
  logic              grant_ok;
  logic [WORD_W-1:0] shift_reg;
  logic [BC_W-1:0]   bit_cnt;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % N_REQ);
      if (!grant_ok && req_valid[cand]) begin
        grant_ok = 1'b1;
        grant    = cand;
      end
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = '0;
    det_in     = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_ok) begin
          next_state       = SHIFT;
          req_ready[grant] = reset_n;
        end
      end
      SHIFT: begin
        det_in = shift_reg[WORD_W-1];
        busy   = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          next_state = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        busy      = 1'b1;
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // det_out is sampled in the same cycle that det_in presents the bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr       <= PTR_INIT;
      shift_reg <= '0;
      bit_cnt   <= '0;
      rsp_count <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            shift_reg <= req_data[int'(grant)*WORD_W +: WORD_W];
            rsp_id    <= grant;
            rsp_count <= '0;
            bit_cnt   <= '0;
            ptr       <= grant;
          end
        end
        SHIFT: begin
          rsp_count <= rsp_count + CNT_W'(det_out);
          shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
          bit_cnt   <= bit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_detect_sched.sv
// Directed testbench for serial_detect_sched with a behavioural "11" Mealy detector attached to det_in/det_out.
// Expected grants, bit streams and hit counts are hand-computed per job.
module tb_serial_detect_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_count;
  logic        rsp_ready = 1'b0;
  logic        det_in;
  logic        det_out;
  logic        busy;
  logic        det_last = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // "11" Mealy detector: a hit occurs when the current bit and the previous bit are both 1.
  always @(posedge clk) det_last <= det_in;
  assign det_out = det_in & det_last;

  serial_detect_sched #(.N_REQ(4), .WORD_W(8), .CNT_W(4), .ID_W(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .rsp_ready (rsp_ready),
    .det_in    (det_in),
    .det_out   (det_out),
    .busy      (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input int gid, input logic [7:0] word);
    req_valid = mask;
    req_data[gid*8 +: 8] = word;
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset_n   = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (cycles) tick();
    reset_n = 1'b1;
    #1;
  endtask

  // One complete job: grant cycle, eight serial bits, optional stall in DONE, then the handshake.
  task automatic run_job(input logic [3:0] mask, input int gid, input logic [7:0] word,
                         input int exp_cnt, input int stall, input int change_at);
    applyStimulus(mask, gid, word);
    checkOutput($sformatf("grant%0d_ready", gid), 32'(req_ready), 32'(1) << gid);
    checkOutput("grant_busy", 32'(busy), 32'd0);
    checkOutput("grant_det_in", 32'(det_in), 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == change_at) begin
        req_data[gid*8 +: 8] = ~word;
        #1;
      end
      checkOutput($sformatf("job%0d_bit%0d", gid, i), 32'(det_in), 32'(word[7-i]));
      if (i == 0) begin
        checkOutput("shift_ready", 32'(req_ready), 32'd0);
        checkOutput("shift_busy", 32'(busy), 32'd1);
        checkOutput("shift_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      tick();
    end
    for (int s = 0; s <= stall; s++) begin
      checkOutput($sformatf("done_valid_s%0d", s), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("done_id_s%0d", s), 32'(rsp_id), 32'(gid));
      checkOutput($sformatf("done_count_s%0d", s), 32'(rsp_count), 32'(exp_cnt));
      checkOutput($sformatf("done_ready_s%0d", s), 32'(req_ready), 32'd0);
      checkOutput($sformatf("done_det_in_s%0d", s), 32'(det_in), 32'd0);
      checkOutput($sformatf("done_busy_s%0d", s), 32'(busy), 32'd1);
      if (s < stall) tick();
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("handshake_no_grant", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 1'b0;
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("idle_det_in", 32'(det_in), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    do_reset(2);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_rsp_count", 32'(rsp_count), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_det_in", 32'(det_in), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    tick();
    checkOutput("idle_no_req_ready", 32'(req_ready), 32'd0);
    checkOutput("idle_no_req_busy", 32'(busy), 32'd0);

    run_job(4'b0001, 0, 8'hFF, 7, 0, -1);
    run_job(4'b0001, 0, 8'b10110111, 3, 0, -1);
    run_job(4'b0001, 0, 8'h00, 0, 0, -1);
    run_job(4'b0001, 0, 8'hAA, 0, 0, -1);

    // Fresh pointer so the round-robin order starts at requester 0.
    do_reset(1);
    req_data = {4{8'hFF}};
    run_job(4'b1111, 0, 8'hFF, 7, 5, -1);
    run_job(4'b1111, 1, 8'hFF, 7, 0, -1);
    run_job(4'b1111, 2, 8'hFF, 7, 0, -1);
    run_job(4'b1111, 3, 8'hFF, 7, 0, -1);
    run_job(4'b1111, 0, 8'hFF, 7, 0, -1);
    run_job(4'b1010, 1, 8'hFF, 7, 0, -1);
    run_job(4'b1010, 3, 8'hFF, 7, 0, -1);

    run_job(4'b0010, 1, 8'h3C, 3, 0, 3);

    // Reset in the middle of a req2 job: the job must vanish and the pointer must return to N_REQ-1.
    applyStimulus(4'b0100, 2, 8'hFF);
    checkOutput("mid_grant2_ready", 32'(req_ready), 32'b0100);
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("mid_bit%0d", i), 32'(det_in), 32'd1);
      tick();
    end
    reset_n   = 1'b0;
    req_valid = '0;
    #1;
    tick();
    reset_n = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("midrst_rsp_count", 32'(rsp_count), 32'd0);
    checkOutput("midrst_det_in", 32'(det_in), 32'd0);
    tick();
    checkOutput("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    req_data[7:0] = 8'hFF;
    run_job(4'b1001, 0, 8'hFF, 7, 0, -1);
    run_job(4'b1001, 3, 8'hC3, 2, 0, -1);

    req_valid = '0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
